// File: rtl/mips_fact_acc.sv
// Memory-mapped iterative factorial accelerator for the MIPS peripheral bus.
// Optional completion interrupt enabled by defining MIPS_FACT_IRQ_EN.
module mips_fact_acc #(
    parameter int N_WIDTH    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int N_MAX      = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [1:0]            a,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq
);

    // Bus handshake: a write is accepted on any rising clk edge where we=1;
    // there is no ready/stall, and reads are purely combinational on a.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [N_WIDTH-1:0] L_N_MAX = N_WIDTH'(N_MAX);
    localparam logic [N_WIDTH-1:0] L_ONE   = N_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_WIDTH-1:0]    r_n;
    logic [N_WIDTH-1:0]    w_n_nxt;
    logic [N_WIDTH-1:0]    r_cnt;
    logic [N_WIDTH-1:0]    w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_product;
    logic [DATA_WIDTH-1:0] w_product_nxt;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] w_result_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_set_irq;
    logic                  w_clr_irq;
    logic                  w_irq_bit;
    logic                  w_wr_n;
    logic                  w_wr_go;
    logic                  w_wr_status;
    logic [DATA_WIDTH-1:0] w_mult;
    logic                  w_unused_wd;

    assign w_wr_n      = we && (a == 2'd0);
    assign w_wr_go     = we && (a == 2'd1) && wd[0];
    assign w_wr_status = we && (a == 2'd2);
    assign w_mult      = r_product * {{(DATA_WIDTH-N_WIDTH){1'b0}}, r_cnt};
    assign w_unused_wd = ^wd[DATA_WIDTH-1:N_WIDTH];

    always_comb begin
        w_state_nxt   = r_state;
        w_n_nxt       = r_n;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        w_result_nxt  = r_result;
        w_done_nxt    = r_done;
        w_err_nxt     = r_err;
        w_set_irq     = 1'b0;
        w_clr_irq     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_n) begin
                    w_n_nxt = wd[N_WIDTH-1:0];
                end
                if (w_wr_go) begin
                    if (r_n <= L_N_MAX) begin
                        w_done_nxt    = 1'b0;
                        w_err_nxt     = 1'b0;
                        w_product_nxt = DATA_WIDTH'(1);
                        w_cnt_nxt     = r_n;
                        w_state_nxt   = S_BUSY;
                    end else begin
                        // Out-of-range n completes at once with an error flag.
                        w_err_nxt    = 1'b1;
                        w_done_nxt   = 1'b1;
                        w_result_nxt = '0;
                        w_set_irq    = 1'b1;
                    end
                end
                if (w_wr_status) begin
                    w_done_nxt = 1'b0;
                    w_err_nxt  = 1'b0;
                    w_clr_irq  = 1'b1;
                end
            end
            S_BUSY: begin
                if (r_cnt > L_ONE) begin
                    w_product_nxt = w_mult;
                    w_cnt_nxt     = r_cnt - L_ONE;
                end else begin
                    w_result_nxt = r_product;
                    w_done_nxt   = 1'b1;
                    w_set_irq    = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_n       <= w_n_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
            r_result  <= w_result_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

`ifdef MIPS_FACT_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (w_set_irq) begin
            r_irq <= 1'b1;
        end else if (w_clr_irq) begin
            r_irq <= 1'b0;
        end
    end

    assign irq       = r_irq;
    assign w_irq_bit = r_irq;
`else
    logic w_unused_irq;

    assign w_unused_irq = w_set_irq | w_clr_irq;
    assign irq          = 1'b0;
    assign w_irq_bit    = 1'b0;
`endif

    always_comb begin
        rd = '0;
        case (a)
            2'd0:    rd = {{(DATA_WIDTH-N_WIDTH){1'b0}}, r_n};
            2'd1:    rd = {{(DATA_WIDTH-1){1'b0}}, (r_state == S_BUSY)};
            2'd2:    rd = {{(DATA_WIDTH-3){1'b0}}, w_irq_bit, r_err, r_done};
            default: rd = r_result;
        endcase
    end

endmodule

// File: tb/tb_mips_fact_acc.sv
// Directed self-checking bench for mips_fact_acc; irq checks follow MIPS_FACT_IRQ_EN.
module tb_mips_fact_acc;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int total;
  int bad;

`ifdef MIPS_FACT_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  mips_fact_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // all driver tasks are called just after a rising edge
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    wd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic status_chk(input string tag, input logic e_err, input logic e_done,
                            input logic e_irq);
    rd_chk(tag, 2'd2, {29'd0, IRQ_ON & e_irq, e_err, e_done});
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, IRQ_ON & e_irq});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    we    = 1'b0;
    a     = 2'd0;
    wd    = '0;
    repeat (2) @(posedge clk);
    #1;
    rd_chk("rst_n", 2'd0, 32'd0);
    rd_chk("rst_busy", 2'd1, 32'd0);
    status_chk("rst_status", 1'b0, 1'b0, 1'b0);
    rd_chk("rst_result", 2'd3, 32'd0);
    rst_n = 1'b1;
    tick();

    // 5! = 120
    bus_write(2'd0, 32'd5);
    rd_chk("n5_nreg", 2'd0, 32'd5);
    bus_write(2'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      rd_chk($sformatf("n5_busy%0d", i), 2'd1, 32'd1);
      tick();
    end
    rd_chk("n5_idle", 2'd1, 32'd0);
    status_chk("n5_status", 1'b0, 1'b1, 1'b1);
    rd_chk("n5_result", 2'd3, 32'h0000_0078);
    bus_write(2'd3, 32'hFFFF_FFFF);
    rd_chk("wr_result_noeff", 2'd3, 32'h0000_0078);
    bus_write(2'd1, 32'd0);
    rd_chk("go0_noop", 2'd1, 32'd0);
    bus_write(2'd2, 32'd0);
    status_chk("clr_status", 1'b0, 1'b0, 1'b0);

    // 12! is the largest in range
    bus_write(2'd0, 32'd12);
    bus_write(2'd1, 32'd1);
    repeat (11) tick();
    rd_chk("n12_busy11", 2'd1, 32'd1);
    tick();
    status_chk("n12_status", 1'b0, 1'b1, 1'b1);
    rd_chk("n12_result", 2'd3, 32'h1C8C_FC00);
    bus_write(2'd2, 32'd0);

    // 13 is out of range: immediate error, no busy
    bus_write(2'd0, 32'd13);
    bus_write(2'd1, 32'd1);
    status_chk("n13_status", 1'b1, 1'b1, 1'b1);
    rd_chk("n13_busy", 2'd1, 32'd0);
    rd_chk("n13_result", 2'd3, 32'd0);
    tick();
    rd_chk("n13_busy_next", 2'd1, 32'd0);
    bus_write(2'd2, 32'd0);

    // n=0 and n=1 both give 1 after one cycle
    bus_write(2'd0, 32'd0);
    bus_write(2'd1, 32'd1);
    rd_chk("n0_busy", 2'd1, 32'd1);
    tick();
    status_chk("n0_status", 1'b0, 1'b1, 1'b1);
    rd_chk("n0_result", 2'd3, 32'd1);
    bus_write(2'd2, 32'd0);
    bus_write(2'd3, 32'd0);
    bus_write(2'd0, 32'd1);
    bus_write(2'd1, 32'd1);
    rd_chk("n1_busy", 2'd1, 32'd1);
    tick();
    status_chk("n1_status", 1'b0, 1'b1, 1'b1);
    rd_chk("n1_result", 2'd3, 32'd1);
    bus_write(2'd2, 32'd0);

    // writes while busy are ignored
    bus_write(2'd0, 32'd6);
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'd3);
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd0);
    rd_chk("n6_nreg_kept", 2'd0, 32'd6);
    rd_chk("n6_busy3", 2'd1, 32'd1);
    tick();
    tick();
    rd_chk("n6_busy5", 2'd1, 32'd1);
    status_chk("n6_notdone", 1'b0, 1'b0, 1'b0);
    rd_chk("n6_result_hold", 2'd3, 32'd1);
    tick();
    status_chk("n6_status", 1'b0, 1'b1, 1'b1);
    rd_chk("n6_result", 2'd3, 32'h0000_02D0);
    bus_write(2'd2, 32'd0);

    // reset during busy aborts everything
    bus_write(2'd0, 32'd4);
    bus_write(2'd1, 32'd1);
    tick();
    rst_n = 1'b0;
    rd_chk("abort_busy", 2'd1, 32'd0);
    rd_chk("abort_result", 2'd3, 32'd0);
    rd_chk("abort_nreg", 2'd0, 32'd0);
    status_chk("abort_status", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    rd_chk("abort_stays_idle", 2'd1, 32'd0);
    rd_chk("abort_no_partial", 2'd3, 32'd0);

    // completion interrupt and its clear
    bus_write(2'd0, 32'd3);
    bus_write(2'd1, 32'd1);
    status_chk("irq_busy0", 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    status_chk("irq_busy2", 1'b0, 1'b0, 1'b0);
    tick();
    status_chk("irq_done", 1'b0, 1'b1, 1'b1);
    rd_chk("n3_result", 2'd3, 32'd6);
    bus_write(2'd2, 32'd0);
    status_chk("irq_cleared", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
